// File: rtl/rr_arb_2to1_8bits.sv
// rr_arb_2to1_8bits
// Two-requester round-robin arbiter sharing one registered byte channel.
// A grant is held for at most MAX_BURST transfers while the other side waits,
// then handed over directly (no idle bubble). The selected byte and its source
// code are captured in a valid/ready output stage.
//
// Ports:
//   CLK        clock, rising edge
//   RST        synchronous, active-high reset
//   REQ1/REQ2  requester valid
//   DATA1/2    requester data, sampled only on a transfer
//   ACK1/ACK2  requester accepted this cycle (combinational)
//   OUT_VALID  output byte valid (registered)
//   OUT_DATA   output byte (registered)
//   OUT_SEL    source of OUT_DATA: 0 = requester 1, 1 = requester 2
//   OUT_READY  downstream accepts OUT_DATA when high with OUT_VALID
module rr_arb_2to1_8bits #(
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              REQ1,
   input  logic [DATA_W-1:0] DATA1,
   output logic              ACK1,
   input  logic              REQ2,
   input  logic [DATA_W-1:0] DATA2,
   output logic              ACK2,
   output logic              OUT_VALID,
   output logic [DATA_W-1:0] OUT_DATA,
   output logic              OUT_SEL,
   input  logic              OUT_READY
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT1 = 2'd1,
      GRANT2 = 2'd2
   } state_t;

   localparam logic [3:0] LAST_CNT = 4'(MAX_BURST - 1);

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       last, last_nxt;   // last source granted: 0 = req 1, 1 = req 2
   logic       free;
   logic       burst_done;

   assign free       = ~OUT_VALID | OUT_READY;
   assign burst_done = (cnt == LAST_CNT);

   // ACK is held low during reset so no byte is accepted in a reset cycle.
   assign ACK1 = ~RST & (state == GRANT1) & REQ1 & free;
   assign ACK2 = ~RST & (state == GRANT2) & REQ2 & free;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      last_nxt  = last;
      unique case (state)
         IDLE: begin
            // On a tie, requester 1 wins when requester 2 was granted last.
            if (REQ1 & (~REQ2 | last)) begin
               state_nxt = GRANT1;
               last_nxt  = 1'b0;
               cnt_nxt   = 4'd0;
            end else if (REQ2) begin
               state_nxt = GRANT2;
               last_nxt  = 1'b1;
               cnt_nxt   = 4'd0;
            end
         end
         GRANT1: begin
            if (~REQ1) begin
               // Release takes precedence over burst counting.
               cnt_nxt = 4'd0;
               if (REQ2) begin
                  state_nxt = GRANT2;
                  last_nxt  = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end else if (ACK1) begin
               if (burst_done) begin
                  cnt_nxt = 4'd0;
                  if (REQ2) begin
                     state_nxt = GRANT2;
                     last_nxt  = 1'b1;
                  end
               end else begin
                  cnt_nxt = cnt + 4'd1;
               end
            end
         end
         GRANT2: begin
            if (~REQ2) begin
               cnt_nxt = 4'd0;
               if (REQ1) begin
                  state_nxt = GRANT1;
                  last_nxt  = 1'b0;
               end else begin
                  state_nxt = IDLE;
               end
            end else if (ACK2) begin
               if (burst_done) begin
                  cnt_nxt = 4'd0;
                  if (REQ1) begin
                     state_nxt = GRANT1;
                     last_nxt  = 1'b0;
                  end
               end else begin
                  cnt_nxt = cnt + 4'd1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         cnt   <= 4'd0;
         last  <= 1'b1;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         last  <= last_nxt;
      end
   end

   // Output stage: a transfer loads the byte even when the consumer takes the
   // current one in the same cycle, keeping one byte per cycle throughput.
   always_ff @(posedge CLK) begin
      if (RST) begin
         OUT_VALID <= 1'b0;
         OUT_DATA  <= '0;
         OUT_SEL   <= 1'b0;
      end else if (ACK1) begin
         OUT_VALID <= 1'b1;
         OUT_DATA  <= DATA1;
         OUT_SEL   <= 1'b0;
      end else if (ACK2) begin
         OUT_VALID <= 1'b1;
         OUT_DATA  <= DATA2;
         OUT_SEL   <= 1'b1;
      end else if (OUT_READY) begin
         OUT_VALID <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_arb_2to1_8bits.sv
// Bench for rr_arb_2to1_8bits: two instances (MAX_BURST 4 and 1) share the
// stimulus; a transaction-level model per instance is compared every cycle,
// and directed scenarios add literal expectations.
module tb_rr_arb_2to1_8bits;

   logic       CLK = 1'b0;
   logic       RST, REQ1, REQ2, OUT_READY;
   logic [7:0] DATA1, DATA2;
   logic       a1 [2];
   logic       a2 [2];
   logic       ov [2];
   logic       os [2];
   logic [7:0] od [2];

   int checks = 0;
   int fails  = 0;

   always #5 CLK = ~CLK;

   rr_arb_2to1_8bits #(.DATA_W(8), .MAX_BURST(4)) dut0 (
      .CLK(CLK), .RST(RST),
      .REQ1(REQ1), .DATA1(DATA1), .ACK1(a1[0]),
      .REQ2(REQ2), .DATA2(DATA2), .ACK2(a2[0]),
      .OUT_VALID(ov[0]), .OUT_DATA(od[0]), .OUT_SEL(os[0]),
      .OUT_READY(OUT_READY));

   rr_arb_2to1_8bits #(.DATA_W(8), .MAX_BURST(1)) dut1 (
      .CLK(CLK), .RST(RST),
      .REQ1(REQ1), .DATA1(DATA1), .ACK1(a1[1]),
      .REQ2(REQ2), .DATA2(DATA2), .ACK2(a2[1]),
      .OUT_VALID(ov[1]), .OUT_DATA(od[1]), .OUT_SEL(os[1]),
      .OUT_READY(OUT_READY));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // owner: 0 none, 1 or 2; done: transfers completed in the current grant.
   int mb [2];
   int own [2], done [2], lst [2], mod [2], mos [2];
   bit mov [2];
   bit r [3];
   int d [3];
   bit ea [3];
   bit fr;
   int w, oth, pick;

   initial begin
      mb[0] = 4; mb[1] = 1;
      for (int i = 0; i < 2; i++) begin
         own[i] = 0; done[i] = 0; lst[i] = 2; mov[i] = 0; mod[i] = 0; mos[i] = 0;
      end
      forever begin
         @(negedge CLK);
         r[1] = REQ1; r[2] = REQ2; d[1] = DATA1; d[2] = DATA2;
         for (int i = 0; i < 2; i++) begin
            fr    = !mov[i] || OUT_READY;
            ea[0] = 0;
            ea[1] = !RST && own[i] == 1 && r[1] && fr;
            ea[2] = !RST && own[i] == 2 && r[2] && fr;
            chk($sformatf("model%0d ACK1", i), a1[i], ea[1]);
            chk($sformatf("model%0d ACK2", i), a2[i], ea[2]);
            chk($sformatf("model%0d OUT_VALID", i), ov[i], mov[i]);
            chk($sformatf("model%0d OUT_DATA", i), od[i], mod[i]);
            chk($sformatf("model%0d OUT_SEL", i), os[i], mos[i]);
            if (RST) begin
               own[i] = 0; done[i] = 0; lst[i] = 2; mov[i] = 0; mod[i] = 0; mos[i] = 0;
            end else begin
               if (ea[1] || ea[2]) begin
                  w = ea[1] ? 1 : 2;
                  mov[i] = 1; mod[i] = d[w]; mos[i] = w - 1;
               end else if (OUT_READY) begin
                  mov[i] = 0;
               end
               if (own[i] == 0) begin
                  pick = (r[1] && r[2]) ? (lst[i] == 1 ? 2 : 1) : r[1] ? 1 : r[2] ? 2 : 0;
                  if (pick != 0) begin
                     own[i] = pick; lst[i] = pick; done[i] = 0;
                  end
               end else begin
                  oth = 3 - own[i];
                  if (!r[own[i]]) begin
                     own[i] = r[oth] ? oth : 0;
                     if (own[i] != 0) lst[i] = own[i];
                     done[i] = 0;
                  end else if (ea[own[i]]) begin
                     done[i]++;
                     if (done[i] == mb[i]) begin
                        done[i] = 0;
                        if (r[oth]) begin
                           own[i] = oth; lst[i] = oth;
                        end
                     end
                  end
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      REQ1 = 0; REQ2 = 0; OUT_READY = 1; RST = 1;
      tick();
      RST = 0;
   endtask

   logic [7:0] exp_seq [12];
   int k1, k2;

   initial begin
      RST = 1; REQ1 = 1; REQ2 = 1; OUT_READY = 1; DATA1 = 8'h5A; DATA2 = 8'hA5;
      tick();

      // Reset held with both requests high: everything stays zero.
      repeat (3) begin
         @(negedge CLK);
         chk("rst ACK1", a1[0], 0);
         chk("rst ACK2", a2[0], 0);
         chk("rst OUT_VALID", ov[0], 0);
         chk("rst OUT_DATA", od[0], 0);
         chk("rst OUT_SEL", os[0], 0);
         tick();
      end
      RST = 0;
      @(negedge CLK);
      chk("post-rst ACK1 c0", a1[0], 0);
      tick();
      @(negedge CLK);
      chk("post-rst ACK1 c1", a1[0], 1);
      chk("post-rst ACK2 c1", a2[0], 0);
      tick();

      // Single source, 8 back-to-back bytes across a burst wrap.
      do_reset();
      for (int c = 0; c < 10; c++) begin
         REQ1 = (c <= 8); DATA1 = 8'(17 * c);
         @(negedge CLK);
         chk($sformatf("single ACK1 c%0d", c), a1[0], (c >= 1 && c <= 8));
         chk($sformatf("single OUT_VALID c%0d", c), ov[0], (c >= 2));
         if (c >= 2) begin
            chk($sformatf("single OUT_DATA c%0d", c), od[0], 17 * (c - 1));
            chk($sformatf("single OUT_SEL c%0d", c), os[0], 0);
         end
         tick();
      end

      // Contention: bursts of 4 (dut0) and strict alternation (dut1).
      exp_seq[0] = 8'hA0; exp_seq[1] = 8'hA1; exp_seq[2]  = 8'hA2; exp_seq[3]  = 8'hA3;
      exp_seq[4] = 8'hB0; exp_seq[5] = 8'hB1; exp_seq[6]  = 8'hB2; exp_seq[7]  = 8'hB3;
      exp_seq[8] = 8'hA4; exp_seq[9] = 8'hA5; exp_seq[10] = 8'hA6; exp_seq[11] = 8'hA7;
      do_reset();
      REQ1 = 1; REQ2 = 1; k1 = 0; k2 = 0;
      for (int c = 0; c < 14; c++) begin
         DATA1 = 8'(8'hA0 + k1); DATA2 = 8'(8'hB0 + k2);
         @(negedge CLK);
         if (c >= 2) begin
            chk($sformatf("cont OUT_VALID c%0d", c), ov[0], 1);
            chk($sformatf("cont OUT_DATA c%0d", c), od[0], exp_seq[c - 2]);
            chk($sformatf("cont OUT_SEL c%0d", c), os[0], ((c - 2) / 4) % 2);
            chk($sformatf("alt OUT_VALID c%0d", c), ov[1], 1);
            chk($sformatf("alt OUT_SEL c%0d", c), os[1], (c - 2) % 2);
         end
         k1 += int'(a1[0]); k2 += int'(a2[0]);
         tick();
      end

      // Backpressure mid-burst: 2 transfers, 3 stalled cycles, 2 more, handover.
      do_reset();
      REQ1 = 1; REQ2 = 1; k1 = 0;
      for (int c = 0; c < 9; c++) begin
         OUT_READY = !(c >= 3 && c <= 5);
         DATA1 = 8'(8'hA0 + k1); DATA2 = 8'hB0;
         @(negedge CLK);
         chk($sformatf("bp ACK1 c%0d", c), a1[0], (c == 1 || c == 2 || c == 6 || c == 7));
         chk($sformatf("bp ACK2 c%0d", c), a2[0], (c == 8));
         if (c >= 3 && c <= 5) begin
            chk($sformatf("bp OUT_VALID c%0d", c), ov[0], 1);
            chk($sformatf("bp OUT_DATA c%0d", c), od[0], 8'hA1);
         end
         k1 += int'(a1[0]);
         tick();
      end
      OUT_READY = 1;

      // Early release of GRANT2 after one transfer; REQ2 returns at once.
      do_reset();
      DATA1 = 8'h50; DATA2 = 8'h60;
      for (int c = 0; c < 8; c++) begin
         REQ2 = (c != 2); REQ1 = (c >= 1);
         @(negedge CLK);
         chk($sformatf("early ACK1 c%0d", c), a1[0], (c >= 3 && c <= 6));
         chk($sformatf("early ACK2 c%0d", c), a2[0], (c == 1 || c == 7));
         if (c == 4) begin
            chk("early OUT_VALID c4", ov[0], 1);
            chk("early OUT_SEL c4", os[0], 0);
         end
         tick();
      end

      // Reset during GRANT2 with a byte in flight.
      do_reset();
      REQ2 = 1; REQ1 = 0;
      tick();
      REQ1 = 1;
      @(negedge CLK);
      chk("midrst ACK2 c1", a2[0], 1);
      tick();
      RST = 1;
      @(negedge CLK);
      chk("midrst OUT_VALID c2", ov[0], 1);
      tick();
      RST = 0;
      @(negedge CLK);
      chk("midrst OUT_VALID c3", ov[0], 0);
      chk("midrst ACK1 c3", a1[0], 0);
      chk("midrst ACK2 c3", a2[0], 0);
      tick();
      @(negedge CLK);
      chk("midrst ACK1 c4", a1[0], 1);
      chk("midrst ACK2 c4", a2[0], 0);
      tick();

      // Randomized traffic, backpressure and occasional reset.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(7) == 0) REQ1 = ~REQ1;
         if ($urandom_range(7) == 0) REQ2 = ~REQ2;
         DATA1     = 8'($urandom);
         DATA2     = 8'($urandom);
         OUT_READY = ($urandom_range(3) != 0);
         RST       = ($urandom_range(199) == 0);
         tick();
      end
      RST = 0;
      @(negedge CLK);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
